ysyx_22050612_mem_responder: RTL and testbench

Memory responder: the target side of the load/store access path that the execute unit drives. It accepts one doubleword read or byte-masked write request at a time over a valid/ready channel, and models a fixed access latency. It services the request from an internal doubleword array and returns data plus an error flag over a valid/ready response channel. It replaces the zero-latency DPI memory model for multi-cycle LSU bring-up.

---
 rtl/ysyx_22050612_mem_responder.sv | 153 +++++++++++++++
 tb/tb_ysyx_22050612_mem_responder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ysyx_22050612_mem_responder.sv
// Fixed-latency doubleword memory responder for LSU bring-up.
// One request in flight; byte-masked writes, full-doubleword reads, range-checked.
module ysyx_22050612_mem_responder #(
  parameter int          ADDR_W  = 10,
  parameter int          LATENCY = 2,
  parameter logic [63:0] BASE    = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] acc_cnt
);

  localparam int          DEPTH = 1 << ADDR_W;
  localparam logic [63:0] LIMIT = BASE + (64'd1 << (ADDR_W + 3));

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        state_q,    state_d;
  logic [3:0]        cnt_q,      cnt_d;
  logic              wen_q,      wen_d;
  logic              in_range_q, in_range_d;
  logic [ADDR_W-1:0] idx_q,      idx_d;
  logic [63:0]       wdata_q,    wdata_d;
  logic [7:0]        wmask_q,    wmask_d;
  logic [63:0]       rdata_q,    rdata_d;
  logic              err_q,      err_d;
  logic [31:0]       acc_q,      acc_d;
  logic              mem_we_s;
  logic [63:0]       offset_s;
  logic              addr_unused_s;

  logic [63:0] mem_q [0:DEPTH-1];

  // Range and index are resolved at accept time so later req_* changes are irrelevant.
  assign offset_s      = req_addr - BASE;
  assign addr_unused_s = ^{offset_s[63:ADDR_W+3], offset_s[2:0]};

  assign req_ready  = (state_q == ST_IDLE) && !rst;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign acc_cnt    = acc_q;

  // Next-state, request latch, access and response bookkeeping.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wen_d      = wen_q;
    in_range_d = in_range_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    acc_d      = acc_q;
    mem_we_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wen_d      = req_wen;
          in_range_d = (req_addr >= BASE) && (req_addr < LIMIT);
          idx_d      = offset_s[ADDR_W+2:3];
          wdata_d    = req_wdata;
          wmask_d    = req_wmask;
          cnt_d      = 4'(LATENCY - 1);
          state_d    = ST_WAIT;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_RESP;
          if (!in_range_q) begin
            rdata_d = 64'd0;
            err_d   = 1'b1;
          end else if (wen_q) begin
            mem_we_s = 1'b1;
            rdata_d  = 64'd0;
            err_d    = 1'b0;
          end else begin
            rdata_d = mem_q[idx_q];
            err_d   = 1'b0;
          end
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          acc_d   = acc_q + 32'd1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and response registers; reset dominates any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      wen_q      <= 1'b0;
      in_range_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 64'd0;
      wmask_q    <= 8'd0;
      rdata_q    <= 64'd0;
      err_q      <= 1'b0;
      acc_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wen_q      <= wen_d;
      in_range_q <= in_range_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      acc_q      <= acc_d;
    end
  end

  // Array is never reset; a reset edge suppresses a pending write.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      for (int i = 0; i < 8; i++) begin
        if (wmask_q[i]) begin
          mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050612_mem_responder.sv
// Scoreboard bench for ysyx_22050612_mem_responder: a byte-level memory model predicts
// each response, which is queued at request time and popped when resp_valid appears.
module tb_ysyx_22050612_mem_responder;

  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] LIMIT = BASE + 64'd8192;
  localparam int          LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic [31:0] acc_cnt;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] acc_exp = 32'd0;
  logic [64:0] sb_q [$];
  logic [63:0] mm [logic [63:0]];

  ysyx_22050612_mem_responder dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .acc_cnt(acc_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction: predict, drive, measure latency, optional backpressure, handshake.
  task automatic do_op(input string tag, input logic wen, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [7:0] wmask, input int hold);
    logic [63:0] key, cur, held;
    logic [64:0] exp;
    int          lat;
    key = (addr - BASE) >> 3;
    if (!(addr >= BASE && addr < LIMIT)) begin
      sb_q.push_back({1'b1, 64'd0});
    end else if (wen) begin
      cur = mm.exists(key) ? mm[key] : 64'd0;
      for (int i = 0; i < 8; i++) begin
        if (wmask[i]) cur[8*i +: 8] = wdata[8*i +: 8];
      end
      mm[key] = cur;
      sb_q.push_back({1'b0, 64'd0});
    end else begin
      sb_q.push_back({1'b0, mm[key]});
    end

    @(negedge clk);
    chk({tag, ".req_ready_idle"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_wen = ~wen; req_addr = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom}; req_wmask = 8'($urandom);
    chk({tag, ".req_ready_busy"}, 64'(req_ready), 64'd0);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(LAT + 1));
    exp = sb_q.pop_front();
    chk({tag, ".rdata"}, resp_rdata, exp[63:0]);
    chk({tag, ".err"}, 64'(resp_err), 64'(exp[64]));
    held = resp_rdata;

    for (int h = 0; h < hold; h++) begin
      req_valid = (h == 1);
      @(negedge clk);
      chk({tag, ".bp_valid"}, 64'(resp_valid), 64'd1);
      chk({tag, ".bp_rdata"}, resp_rdata, held);
      chk({tag, ".bp_req_ready"}, 64'(req_ready), 64'd0);
      chk({tag, ".bp_acc"}, 64'(acc_cnt), 64'(acc_exp));
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    acc_exp    = acc_exp + 32'd1;
    chk({tag, ".acc_cnt"}, 64'(acc_cnt), 64'(acc_exp));
    chk({tag, ".back_idle"}, 64'(req_ready), 64'd1);
    chk({tag, ".resp_dropped"}, 64'(resp_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = 64'd0;
    req_wdata = 64'd0; req_wmask = 8'd0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.req_ready", 64'(req_ready), 64'd0);
    chk("rst.resp_valid", 64'(resp_valid), 64'd0);
    chk("rst.rdata", resp_rdata, 64'd0);
    chk("rst.err", 64'(resp_err), 64'd0);
    chk("rst.acc_cnt", 64'(acc_cnt), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst.ready_after", 64'(req_ready), 64'd1);

    do_op("wr10",   1'b1, BASE + 64'h10, 64'h1122_3344_5566_7788, 8'hff, 0);
    do_op("rd10",   1'b0, BASE + 64'h10, 64'd0,                   8'h00, 0);
    do_op("wr_m0f", 1'b1, BASE + 64'h10, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0f, 0);
    do_op("rd_m0f", 1'b0, BASE + 64'h10, 64'd0,                   8'h00, 0);
    do_op("wr_m80", 1'b1, BASE + 64'h10, 64'hCC00_0000_0000_0000, 8'h80, 0);
    do_op("rd_m80", 1'b0, BASE + 64'h10, 64'd0,                   8'h00, 0);
    do_op("wr_m00", 1'b1, BASE + 64'h10, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00, 0);
    do_op("rd_m00", 1'b0, BASE + 64'h10, 64'd0,                   8'h00, 0);
    do_op("rd_bp",  1'b0, BASE + 64'h10, 64'd0,                   8'h00, 5);
    do_op("rd_lo",  1'b0, BASE - 64'd8,  64'd0,                   8'h00, 0);
    do_op("wr0",    1'b1, BASE,          64'h0123_4567_89AB_CDEF, 8'hff, 0);
    do_op("wr_hi",  1'b1, LIMIT,         64'hFFFF_FFFF_FFFF_FFFF, 8'hff, 0);
    do_op("rd0",    1'b0, BASE,          64'd0,                   8'h00, 0);
    do_op("wr13",   1'b1, BASE + 64'h13, 64'h5A5A_0F0F_1234_9876, 8'hff, 2);
    do_op("rd_al",  1'b0, BASE + 64'h10, 64'd0,                   8'h00, 0);

    // Reset during WAIT: the accepted write must never land.
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = BASE + 64'h10;
    req_wdata = 64'd0; req_wmask = 8'hff;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rstw.req_ready_in_rst", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    acc_exp = 32'd0;
    @(negedge clk);
    chk("rstw.resp_valid", 64'(resp_valid), 64'd0);
    chk("rstw.req_ready", 64'(req_ready), 64'd1);
    chk("rstw.acc_cnt", 64'(acc_cnt), 64'd0);
    do_op("rd_after_rst", 1'b0, BASE + 64'h10, 64'd0, 8'h00, 0);

    chk("sb.empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
